// File: rtl/sqrt2_host_pkg.sv
// Shared types and FP16 constants for the sqrt2 bus-master host.
package sqrt2_host_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    TURN  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4,
    GAP   = 3'd5
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              nan;
    logic              pinf;
    logic              ninf;
    logic              timeout;
  } rsp_t;

  localparam logic [DATA_W-1:0] FP16_ONE  = 16'h3C00;
  localparam logic [DATA_W-1:0] FP16_PINF = 16'h7C00;
  localparam logic [DATA_W-1:0] FP16_NINF = 16'hFC00;
  localparam logic [DATA_W-1:0] FP16_QNAN = 16'h7E00;

endpackage

// File: rtl/sqrt2_io_pad.sv
// Bidirectional pad for the shared IO_DATA bus; the only tristate in the host.
module sqrt2_io_pad #(
  parameter int unsigned W = 16
) (
  input  logic         oe,
  input  logic [W-1:0] dout,
  output logic [W-1:0] din,
  inout  wire  [W-1:0] pad
);

  assign pad = oe ? dout : {W{1'bz}};
  assign din = pad;

endmodule

// File: rtl/sqrt2_host.sv
// Bus master for one sqrt2 unit: drives the operand, waits for RESULT, returns
// the captured root and special-case flags on a valid/ready response port.
module sqrt2_host
  import sqrt2_host_pkg::*;
#(
  parameter int unsigned DRIVE_CYCLES = 1,
  parameter int unsigned TURN_CYCLES  = 1,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_nan,
  output logic              rsp_pinf,
  output logic              rsp_ninf,
  output logic              rsp_timeout,
  output logic              busy,
  inout  wire  [DATA_W-1:0] IO_DATA,
  output logic              ENABLE,
  input  logic              RESULT,
  input  logic              IS_NAN,
  input  logic              IS_PINF,
  input  logic              IS_NINF
);

  // One shared down-counter times every phase, so it must hold the largest duration.
  localparam int unsigned MAX_A  = (DRIVE_CYCLES > TURN_CYCLES) ? DRIVE_CYCLES : TURN_CYCLES;
  localparam int unsigned MAX_B  = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNT_MX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W  = $clog2(CNT_MX + 1);

  localparam logic [CNT_W-1:0] DRIVE_LD = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               oe_q, oe_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               en_q, en_d;
  logic               rdy_q, rdy_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  rsp_t               rsp_q, rsp_d;
  logic [DATA_W-1:0]  din;

  sqrt2_io_pad #(.W(DATA_W)) u_pad (
    .oe   (oe_q),
    .dout (dout_q),
    .din  (din),
    .pad  (IO_DATA)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    en_d    = en_q;
    rdy_d   = rdy_q;
    vld_d   = vld_q;
    rsp_d   = rsp_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && rdy_q) begin
          state_d = DRIVE;
          cnt_d   = DRIVE_LD;
          oe_d    = 1'b1;
          dout_d  = req_data;
          en_d    = 1'b1;
          rdy_d   = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          oe_d = 1'b0;
          if (TURN_CYCLES == 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LD;
          end else begin
            state_d = TURN;
            cnt_d   = TURN_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d = WAIT;
          cnt_d   = WAIT_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // RESULT takes priority over the timeout on the final WAIT cycle.
      WAIT: begin
        if (RESULT) begin
          rsp_d   = '{data: din, nan: IS_NAN, pinf: IS_PINF, ninf: IS_NINF, timeout: 1'b0};
          state_d = RESP;
          en_d    = 1'b0;
          vld_d   = 1'b1;
        end else if (cnt_q == '0) begin
          rsp_d   = '{data: '0, nan: 1'b0, pinf: 1'b0, ninf: 1'b0, timeout: 1'b1};
          state_d = RESP;
          en_d    = 1'b0;
          vld_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = GAP;
          vld_d   = 1'b0;
          cnt_d   = GAP_LD;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        oe_d    = 1'b0;
        en_d    = 1'b0;
        rdy_d   = 1'b1;
        vld_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign req_ready   = rdy_q;
  assign rsp_valid   = vld_q;
  assign rsp_data    = rsp_q.data;
  assign rsp_nan     = rsp_q.nan;
  assign rsp_pinf    = rsp_q.pinf;
  assign rsp_ninf    = rsp_q.ninf;
  assign rsp_timeout = rsp_q.timeout;
  assign busy        = busy_q;
  assign ENABLE      = en_q;

endmodule
